// File: rtl/sram_apb_pkg.sv
// sram_apb_pkg: shared FSM state type and constants for the APB-to-SRAM
// sequencer (optional error reporting: SRAM_APB_ERR_EN).
package sram_apb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RWAIT,
        RESP
    } state_t;

    localparam int DEF_SRAM_DEPTH = 160;
    localparam int IDX_MSB        = 9;
    localparam int IDX_LSB        = 2;
    localparam int IDX_W          = IDX_MSB - IDX_LSB + 1;
    localparam int TMR_W          = 8;

endpackage

// File: rtl/sram_rd_timer.sv
// sram_rd_timer: counts cycles spent waiting for SRAM ready and flags
// the last permitted wait cycle.
module sram_rd_timer
    import sram_apb_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(LIMIT - 1);

    logic [TMR_W-1:0] r_cnt;

    // wait-cycle counter, cleared when a read strobe is issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TMR_W'(1);
        end
    end

    assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/sram_apb_ctrl.sv
// sram_apb_ctrl: APB slave turning each transfer into one SRAM strobe.
// Define SRAM_APB_ERR_EN to report range/timeout errors on pslverr.
module sram_apb_ctrl
    import sram_apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int SRAM_DEPTH     = DEF_SRAM_DEPTH,
    parameter int RD_TIMEOUT     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]               pwdata,
    output logic [31:0]               prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic                      we_n,
    output logic                      read_n,
    output logic [APB_ADDR_WIDTH-1:0] w_addr,
    output logic [APB_ADDR_WIDTH-1:0] r_addr,
    output logic [31:0]               write_data,
    input  logic                      ry,
    input  logic [31:0]               sram_rdata
);

    localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(SRAM_DEPTH);

    state_t                    r_state;
    state_t                    w_next;
    logic [IDX_W-1:0]          w_idx;
    logic [APB_ADDR_WIDTH-1:0] w_idx_ext;
    logic                      w_in_range;
    logic                      w_ld_wr;
    logic                      w_ld_rd;
    logic                      w_cap;
    logic                      w_zero;
    logic                      w_err;
    logic                      w_tmr_clr;
    logic                      w_tmr_en;
    logic                      w_expired;
    logic [31:0]               r_prdata;
    logic                      r_pready;
    logic                      r_pslverr;
    logic [APB_ADDR_WIDTH-1:0] r_waddr;
    logic [APB_ADDR_WIDTH-1:0] r_raddr;
    logic [31:0]               r_wdata;

    assign w_idx      = paddr[IDX_MSB:IDX_LSB];
    assign w_idx_ext  = {{(APB_ADDR_WIDTH-IDX_W){1'b0}}, w_idx};
    assign w_in_range = (paddr[APB_ADDR_WIDTH-1:IDX_MSB+1] == '0)
                        && ({1'b0, w_idx} < DEPTH_L);

    sram_rd_timer #(
        .LIMIT(RD_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expired(w_expired)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next state and datapath controls
    always_comb begin
        w_next    = r_state;
        w_ld_wr   = 1'b0;
        w_ld_rd   = 1'b0;
        w_cap     = 1'b0;
        w_zero    = 1'b0;
        w_err     = 1'b0;
        w_tmr_clr = 1'b0;
        w_tmr_en  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (psel && penable) begin
                    if (!w_in_range) begin
                        w_next = RESP;
                        w_err  = 1'b1;
                        w_zero = !pwrite;
                    end else if (pwrite) begin
                        w_next  = WR;
                        w_ld_wr = 1'b1;
                    end else begin
                        w_next  = RD;
                        w_ld_rd = 1'b1;
                    end
                end
            end
            WR: w_next = RESP;
            RD: begin
                w_next    = RWAIT;
                w_tmr_clr = 1'b1;
            end
            RWAIT: begin
                if (ry) begin
                    w_cap  = 1'b1;
                    w_next = RESP;
                end else begin
                    w_tmr_en = 1'b1;
                    if (w_expired) begin
                        w_zero = 1'b1;
                        w_err  = 1'b1;
                        w_next = RESP;
                    end
                end
            end
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // registered APB response and SRAM address/data holding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_waddr   <= '0;
            r_raddr   <= '0;
            r_wdata   <= '0;
        end else begin
            r_pready <= (w_next == RESP);
`ifdef SRAM_APB_ERR_EN
            r_pslverr <= w_err;
`else
            r_pslverr <= 1'b0;
`endif
            if (w_ld_wr) begin
                r_waddr <= w_idx_ext;
                r_wdata <= pwdata;
            end
            if (w_ld_rd) begin
                r_raddr <= w_idx_ext;
            end
            if (w_cap) begin
                r_prdata <= sram_rdata;
            end else if (w_zero) begin
                r_prdata <= '0;
            end
        end
    end

`ifdef SRAM_APB_ERR_EN
    logic w_unused;
    assign w_unused = ^paddr[IDX_LSB-1:0];
`else
    logic w_unused;
    assign w_unused = ^{paddr[IDX_LSB-1:0], w_err};
`endif

    assign we_n       = (r_state != WR);
    assign read_n     = (r_state != RD);
    assign prdata     = r_prdata;
    assign pready     = r_pready;
    assign pslverr    = r_pslverr;
    assign w_addr     = r_waddr;
    assign r_addr     = r_raddr;
    assign write_data = r_wdata;

endmodule

// File: tb/tb_sram_apb_ctrl.sv
// tb_sram_apb_ctrl: APB master, behavioural SRAM with programmable ready
// latency, and a scoreboard of expected transfer results.
module tb_sram_apb_ctrl;

`ifdef SRAM_APB_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    typedef struct {
        int          lat;
        logic [31:0] data;
        logic        err;
        int          ws;
        int          rs;
        logic [11:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        we_n;
    logic        read_n;
    logic [11:0] w_addr;
    logic [11:0] r_addr;
    logic [31:0] write_data;
    logic        ry;
    logic [31:0] sram_rdata;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sram_apb_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .we_n      (we_n),
        .read_n    (read_n),
        .w_addr    (w_addr),
        .r_addr    (r_addr),
        .write_data(write_data),
        .ry        (ry),
        .sram_rdata(sram_rdata)
    );

    // behavioural SRAM: ry rises ry_lat cycles after the read strobe
    logic [31:0] mem [256];
    int          ry_lat = 1;
    int          ry_cd = -1;
    int          ws_cnt = 0;
    int          rs_cnt = 0;
    int          both_cnt = 0;
    logic [11:0] seen_waddr = '0;
    logic [11:0] seen_raddr = '0;

    always @(negedge clk) begin
        if (!we_n && !read_n) both_cnt++;
        if (!we_n) begin
            mem[w_addr[7:0]] = write_data;
            seen_waddr = w_addr;
            ws_cnt++;
        end
        if (!rst) begin
            ry = 1'b0;
            ry_cd = -1;
        end else if (!read_n) begin
            rs_cnt++;
            seen_raddr = r_addr;
            sram_rdata = mem[r_addr[7:0]];
            ry = 1'b0;
            ry_cd = ry_lat;
        end else if (ry_cd > 0) begin
            ry_cd--;
            ry = (ry_cd == 0);
        end else begin
            ry = 1'b0;
        end
    end

    // reference model of one transfer
    logic [31:0] exp_mem [256];
    logic [31:0] exp_prdata = '0;
    exp_t        q[$];

    function automatic exp_t model(input bit wr, input logic [11:0] a,
                                   input logic [31:0] d, input int rl);
        exp_t       e;
        logic [7:0] idx;
        bit         inr;
        idx = a[9:2];
        inr = (a[11:10] == 2'b00) && (idx < 8'd160);
        e.addr = {4'h0, idx};
        e.ws = 0;
        e.rs = 0;
        e.err = 1'b0;
        if (!inr) begin
            e.lat = 1;
            e.err = ERR;
            e.data = wr ? exp_prdata : 32'h0;
        end else if (wr) begin
            e.lat = 2;
            e.ws = 1;
            e.data = exp_prdata;
            exp_mem[idx] = d;
        end else if (rl >= 1 && rl <= 8) begin
            e.lat = 2 + rl;
            e.rs = 1;
            e.data = exp_mem[idx];
        end else begin
            e.lat = 10;
            e.rs = 1;
            e.err = ERR;
            e.data = 32'h0;
        end
        exp_prdata = e.data;
        return e;
    endfunction

    task automatic apb_xfer(input bit wr, input logic [11:0] a,
                            input logic [31:0] d, input int rl,
                            output int lat, output logic [31:0] rd,
                            output logic er, output int ws, output int rs);
        int ws0;
        int rs0;
        @(negedge clk);
        ry_lat = rl;
        ws0 = ws_cnt;
        rs0 = rs_cnt;
        psel = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = a;
        pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (pready) begin
                lat = k;
                break;
            end
        end
        rd = prdata;
        er = pslverr;
        ws = ws_cnt - ws0;
        rs = rs_cnt - rs0;
        psel = 1'b0;
        penable = 1'b0;
    endtask

    task automatic test_reset();
        int lows;
        repeat (3) @(negedge clk);
        total++;
        if ({we_n, read_n} !== 2'b11) begin
            bad++;
            $display("FAIL rst_strobes: got %b want 11", {we_n, read_n});
        end
        total++;
        if ({w_addr, r_addr} !== 24'h0 || write_data !== 32'h0) begin
            bad++;
            $display("FAIL rst_addr: got %h %h %h want 0", w_addr, r_addr, write_data);
        end
        total++;
        if (prdata !== 32'h0 || pready !== 1'b0 || pslverr !== 1'b0) begin
            bad++;
            $display("FAIL rst_resp: got %h %b %b want 0 0 0", prdata, pready, pslverr);
        end
        rst = 1'b1;
        lows = 0;
        repeat (10) begin
            @(negedge clk);
            if (!we_n || !read_n || pready) lows++;
        end
        total++;
        if (lows !== 0) begin
            bad++;
            $display("FAIL idle_quiet: got %0d active cycles want 0", lows);
        end
    endtask

    task automatic test_write();
        exp_t e;
        int lat, ws, rs;
        logic [31:0] rd;
        logic er;
        q.push_back(model(1'b1, 12'h010, 32'hDEADBEEF, 1));
        apb_xfer(1'b1, 12'h010, 32'hDEADBEEF, 1, lat, rd, er, ws, rs);
        e = q.pop_front();
        total++;
        if (lat !== e.lat || er !== e.err) begin
            bad++;
            $display("FAIL wr_resp: got lat=%0d err=%b want lat=%0d err=%b", lat, er, e.lat, e.err);
        end
        total++;
        if (ws !== 1 || rs !== 0 || seen_waddr !== e.addr) begin
            bad++;
            $display("FAIL wr_strobe: got ws=%0d rs=%0d addr=%h want 1 0 %h", ws, rs, seen_waddr, e.addr);
        end
        total++;
        if (rd !== e.data) begin
            bad++;
            $display("FAIL wr_prdata: got %h want %h", rd, e.data);
        end
    endtask

    task automatic test_read();
        exp_t e;
        int lat, ws, rs;
        logic [31:0] rd;
        logic er;
        q.push_back(model(1'b0, 12'h010, 32'h0, 1));
        apb_xfer(1'b0, 12'h010, 32'h0, 1, lat, rd, er, ws, rs);
        e = q.pop_front();
        total++;
        if (lat !== e.lat || er !== e.err) begin
            bad++;
            $display("FAIL rd_resp: got lat=%0d err=%b want lat=%0d err=%b", lat, er, e.lat, e.err);
        end
        total++;
        if (rd !== e.data) begin
            bad++;
            $display("FAIL rd_data: got %h want %h", rd, e.data);
        end
        total++;
        if (rs !== 1 || ws !== 0 || seen_raddr !== e.addr) begin
            bad++;
            $display("FAIL rd_strobe: got rs=%0d ws=%0d addr=%h want 1 0 %h", rs, ws, seen_raddr, e.addr);
        end
    endtask

    task automatic test_range();
        exp_t e;
        int lat, ws, rs;
        logic [31:0] rd;
        logic er;
        logic [11:0] av [3];
        bit wv [3];
        av[0] = 12'h280; wv[0] = 1'b1;
        av[1] = 12'h27C; wv[1] = 1'b1;
        av[2] = 12'h410; wv[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            q.push_back(model(wv[i], av[i], 32'hA5A50F0F, 1));
            apb_xfer(wv[i], av[i], 32'hA5A50F0F, 1, lat, rd, er, ws, rs);
            e = q.pop_front();
            total++;
            if (lat !== e.lat || er !== e.err || rd !== e.data) begin
                bad++;
                $display("FAIL range_%0d: got lat=%0d err=%b data=%h want lat=%0d err=%b data=%h",
                         i, lat, er, rd, e.lat, e.err, e.data);
            end
            total++;
            if (ws !== e.ws || rs !== e.rs) begin
                bad++;
                $display("FAIL range_strobe_%0d: got ws=%0d rs=%0d want %0d %0d", i, ws, rs, e.ws, e.rs);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int lat, ws, rs;
        logic [31:0] rd;
        logic er;
        int rlv [2];
        rlv[0] = 8;
        rlv[1] = -1;
        for (int i = 0; i < 2; i++) begin
            q.push_back(model(1'b0, 12'h27C, 32'h0, rlv[i]));
            apb_xfer(1'b0, 12'h27C, 32'h0, rlv[i], lat, rd, er, ws, rs);
            e = q.pop_front();
            total++;
            if (lat !== e.lat || er !== e.err || rd !== e.data) begin
                bad++;
                $display("FAIL tmo_%0d: got lat=%0d err=%b data=%h want lat=%0d err=%b data=%h",
                         i, lat, er, rd, e.lat, e.err, e.data);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int lat, ws, rs;
        logic [31:0] rd;
        logic er;
        logic [11:0] addrs [8];
        logic [7:0] idx;
        logic [31:0] d;
        int rl;
        for (int i = 0; i < 8; i++) begin
            idx = 8'($urandom_range(0, 159));
            addrs[i] = {2'b00, idx, 2'($urandom_range(0, 3))};
            d = $urandom;
            q.push_back(model(1'b1, addrs[i], d, 1));
            apb_xfer(1'b1, addrs[i], d, 1, lat, rd, er, ws, rs);
            e = q.pop_front();
            total++;
            if (lat !== e.lat || rd !== e.data || ws !== 1 || seen_waddr !== e.addr) begin
                bad++;
                $display("FAIL b2b_wr_%0d: got lat=%0d data=%h ws=%0d addr=%h want %0d %h 1 %h",
                         i, lat, rd, ws, seen_waddr, e.lat, e.data, e.addr);
            end
        end
        for (int i = 0; i < 8; i++) begin
            rl = $urandom_range(1, 6);
            q.push_back(model(1'b0, addrs[i], 32'h0, rl));
            apb_xfer(1'b0, addrs[i], 32'h0, rl, lat, rd, er, ws, rs);
            e = q.pop_front();
            total++;
            if (lat !== e.lat || rd !== e.data || er !== e.err) begin
                bad++;
                $display("FAIL b2b_rd_%0d: got lat=%0d data=%h err=%b want %0d %h %b",
                         i, lat, rd, er, e.lat, e.data, e.err);
            end
        end
        total++;
        if (both_cnt !== 0) begin
            bad++;
            $display("FAIL both_low: got %0d cycles want 0", both_cnt);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int lat, ws, rs;
        logic [31:0] rd;
        logic er;
        int depth [2];
        int busy;
        depth[0] = 1;
        depth[1] = 3;
        for (int i = 0; i < 2; i++) begin
            q.push_back(model(1'b0, 12'h010, 32'h0, 1));
            apb_xfer(1'b0, 12'h010, 32'h0, 1, lat, rd, er, ws, rs);
            e = q.pop_front();
            total++;
            if (lat !== e.lat || rd !== e.data) begin
                bad++;
                $display("FAIL rm_pre_%0d: got lat=%0d data=%h want %0d %h", i, lat, rd, e.lat, e.data);
            end
            @(negedge clk);
            ry_lat = -1;
            psel = 1'b1;
            pwrite = 1'b0;
            paddr = 12'h010;
            @(negedge clk);
            penable = 1'b1;
            repeat (depth[i]) @(negedge clk);
            if (depth[i] == 1) begin
                total++;
                if (read_n !== 1'b0) begin
                    bad++;
                    $display("FAIL rm_strobe_pre: got read_n=%b want 0", read_n);
                end
            end
            rst = 1'b0;
            #1;
            total++;
            if (read_n !== 1'b1 || we_n !== 1'b1 || pready !== 1'b0) begin
                bad++;
                $display("FAIL rm_async_%0d: got read_n=%b we_n=%b pready=%b want 1 1 0",
                         i, read_n, we_n, pready);
            end
            total++;
            if (prdata !== 32'h0 || r_addr !== 12'h0) begin
                bad++;
                $display("FAIL rm_regs_%0d: got prdata=%h r_addr=%h want 0 0", i, prdata, r_addr);
            end
            exp_prdata = 32'h0;
            busy = 0;
            repeat (3) begin
                @(negedge clk);
                if (pready || !read_n) busy++;
            end
            psel = 1'b0;
            penable = 1'b0;
            rst = 1'b1;
            repeat (2) begin
                @(negedge clk);
                if (pready || !read_n) busy++;
            end
            total++;
            if (busy !== 0) begin
                bad++;
                $display("FAIL rm_quiet_%0d: got %0d active cycles want 0", i, busy);
            end
        end
        q.push_back(model(1'b0, 12'h010, 32'h0, 2));
        apb_xfer(1'b0, 12'h010, 32'h0, 2, lat, rd, er, ws, rs);
        e = q.pop_front();
        total++;
        if (lat !== e.lat || rd !== e.data || er !== e.err) begin
            bad++;
            $display("FAIL rm_after: got lat=%0d data=%h err=%b want %0d %h %b",
                     lat, rd, er, e.lat, e.data, e.err);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_range();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_apb_ctrl.md
# sram_apb_ctrl

APB slave that sequences single-word accesses into the 160x32 matrix SRAM wrapper `sram_mem`, sitting directly upstream of it. Each APB transfer becomes exactly one SRAM strobe (`we_n` or `read_n` low for one cycle), with wait states inserted via `pready`. Read data is captured once the SRAM's `ry` goes high. Out-of-range addresses and missing `ry` are detected and reported.

## Interface
- `APB_ADDR_WIDTH`, 12: APB address width; also the width of the SRAM address ports.
- `SRAM_DEPTH`, 160: number of 32-bit words in the SRAM.
- `RD_TIMEOUT`, 8: maximum cycles spent waiting for `ry` (range 1..255).

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `psel` input 1: APB select.
- `penable` input 1: APB enable (access phase).
- `pwrite` input 1: 1 = write, 0 = read.
- `paddr` input APB_ADDR_WIDTH: APB byte address.
- `pwdata` input 32: APB write data.
- `prdata` output 32: APB read data (registered).
- `pready` output 1: transfer complete (registered, one-cycle pulse).
- `pslverr` output 1: transfer error, valid only while `pready`=1.
- `we_n` output 1: SRAM write strobe, active-low.
- `read_n` output 1: SRAM read strobe, active-low.
- `w_addr` output APB_ADDR_WIDTH: SRAM word write address.
- `r_addr` output APB_ADDR_WIDTH: SRAM word read address.
- `write_data` output 32: SRAM write data.
- `ry` input 1: SRAM ready.
- `sram_rdata` input 32: SRAM Q output.

## Operation
- Word index = `paddr[9:2]`. `paddr[1:0]` is ignored.
- Address is in range iff `paddr[APB_ADDR_WIDTH-1:10]`==0 and index < SRAM_DEPTH.
- `w_addr`/`r_addr` carry the index zero-extended to APB_ADDR_WIDTH.
- FSM states and transitions:
  - IDLE: on `psel & penable`, register address/data, then go to WR (write, in range), RD (read, in range), or RESP (out of range, no strobe).
  - WR: `we_n`=0 for this one cycle → RESP.
  - RD: `read_n`=0 for this one cycle → RWAIT; clear timeout counter.
  - RWAIT: if `ry`=1, capture `sram_rdata` into `prdata` → RESP. Otherwise increment counter; when counter reaches RD_TIMEOUT, set `prdata`=0 and flag timeout → RESP.
  - RESP: `pready`=1 for exactly one cycle → IDLE.
- `we_n` and `read_n` are never low simultaneously. Neither strobe is low outside WR/RD.
- `w_addr`, `r_addr` and `write_data` hold their values until the next transfer.
- `prdata` holds its value until the next read completes. Writes do not alter `prdata`.
- Reset values: `we_n`=1, `read_n`=1, `w_addr`=0, `r_addr`=0, `write_data`=0, `prdata`=0, `pready`=0, `pslverr`=0, state IDLE, counter 0.
- Reset asserted mid-transfer: strobes deassert immediately (asynchronously) and the transfer is abandoned with no `pready`.

## Timing
- A = first access-phase cycle.
- Write: `we_n` low in A+1; `pready` high in A+2 (3 access cycles).
- Read with `ry` high one cycle after the strobe: `read_n` low in A+1, `ry` sampled in A+2, `pready` and `prdata` valid in A+3.
- Each extra `ry`-low cycle adds one cycle of latency, capped at RD_TIMEOUT.
- Out of range: `pready` in A+1, no strobe issued.
- `psel`/`penable` are ignored outside IDLE. A master that holds `penable` after `pready` is protocol-illegal and is not checked.

## Configuration
- `SRAM_APB_ERR_EN` defined:
  - `pslverr`=1 with `pready` on out-of-range accesses and on read timeout.
  - Read data in both cases is 0.
- `SRAM_APB_ERR_EN` not defined:
  - `pslverr` is tied to 0.
  - Out-of-range writes are dropped and out-of-range reads return 0.
  - Timeout still terminates the read with `prdata`=0.

## Structure
- Shared package `sram_apb_pkg` holds:
  - the state enum (IDLE, WR, RD, RWAIT, RESP);
  - the default SRAM_DEPTH;
  - the index slice constants (bits 9:2);
  - the timeout counter width (8).
- One sub-module, `sram_rd_timer`: the RWAIT cycle counter with clear/enable inputs and an expiry output.

## Test plan
- Reset then idle: all outputs at reset values; `we_n`=`read_n`=1 for 10 cycles.
- Write 0xDEADBEEF to paddr 0x010: `we_n` low exactly one cycle with `w_addr`=4; `pready` in A+2; `pslverr`=0.
- Read paddr 0x010 with `ry` high one cycle after the strobe: `r_addr`=4, `prdata`=0xDEADBEEF, `pready` in A+3.
- Write to paddr 0x280 (index 160): no strobe; `pready` in A+1; `pslverr`=1 with the macro, 0 without.
- Read with `ry` held low: `pready` after RD_TIMEOUT=8 wait cycles, `prdata`=0, `pslverr`=1 with the macro.
- Assert `rst` during RWAIT: `read_n`=1 and `pready`=0 immediately; the next read completes normally.
